// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB write-port controller.
package btb_pkg;

   localparam int INDEX_BITS  = 5;
   localparam int TAG_BITS    = 30 - INDEX_BITS;
   localparam int NUM_ENTRIES = 1 << INDEX_BITS;

   typedef enum logic {INIT, RUN} btbState_e;

   typedef struct packed {
      logic [29:0] pc_hi;
      logic [31:0] target;
      logic        taken;
   } updEntry_t;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] ST  = 2'b11;

   function automatic logic [1:0] satInc(input logic [1:0] c);
      return (c == ST) ? ST : c + 2'b01;
   endfunction

   function automatic logic [1:0] satDec(input logic [1:0] c);
      return (c == SNT) ? SNT : c - 2'b01;
   endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates until the controller
// can turn them into BTB writes; flush empties it in one cycle.
module btb_upd_fifo import btb_pkg::*; #(
   parameter int QDEPTH = 2
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      flush_i,
   input  logic      push_i,
   input  updEntry_t data_i,
   input  logic      pop_i,
   output updEntry_t data_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam logic [PW:0] DEPTH_C = (PW + 1)'(QDEPTH);

   logic [PW-1:0] wrPtr_q, rdPtr_q;
   logic [PW:0]   count_q;
   updEntry_t     mem_q [QDEPTH];
   logic          doPush, doPop;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;
   assign data_o  = mem_q[rdPtr_q];

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: only entries counted by count_q are ever read.
   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/btb_ctrl.sv
// BTB write-port sequencer: invalidation walk after reset/flush, then queued
// branch-resolution updates; also owns the 2-bit counters gating predictions.
module btb_ctrl import btb_pkg::*; #(
   parameter int QDEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           current_pc,
   input  logic                  btb_tag_match,
   input  logic [31:0]           btb_target,
   output logic                  pred_taken,
   output logic [31:0]           pred_target,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [31:0]           upd_pc,
   input  logic [31:0]           upd_target,
   input  logic                  upd_taken,
   input  logic                  flush_req,
   output logic                  busy,
   output logic                  btb_we,
   output logic [INDEX_BITS-1:0] btb_index,
   output logic [TAG_BITS-1:0]   btb_tag,
   output logic [31:0]           btb_target_wr,
   output logic                  btb_valid_wr
);

   btbState_e             state_q, state_d;
   logic [INDEX_BITS-1:0] walkIdx_q, walkIdx_d;
   logic [1:0]            ctr_q [NUM_ENTRIES];

   logic                  btbWe_q, btbWe_d;
   logic [INDEX_BITS-1:0] btbIndex_q, btbIndex_d;
   logic [TAG_BITS-1:0]   btbTag_q, btbTag_d;
   logic [31:0]           btbTarget_q, btbTarget_d;
   logic                  btbValid_q, btbValid_d;

   logic                  ctrWe;
   logic [INDEX_BITS-1:0] ctrIdx;
   logic [1:0]            ctrVal;

   logic                  fifoFull, fifoEmpty, fifoPush, fifoPop;
   updEntry_t             pushEntry, headEntry;
   logic [INDEX_BITS-1:0] headIdx;
   logic                  unusedBits;

   assign busy       = (state_q == INIT);
   assign upd_ready  = (state_q == RUN) && !fifoFull;
   // A request handshaken alongside a flush is dropped with the rest of the queue.
   assign fifoPush   = upd_valid && upd_ready && !flush_req;
   assign pushEntry  = '{pc_hi: upd_pc[31:2], target: upd_target, taken: upd_taken};
   assign headIdx    = headEntry.pc_hi[INDEX_BITS-1:0];
   assign unusedBits = ^{current_pc[31:INDEX_BITS+2], current_pc[1:0], upd_pc[1:0]};

   btb_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush_req),
      .push_i  (fifoPush),
      .data_i  (pushEntry),
      .pop_i   (fifoPop),
      .data_o  (headEntry),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   always_comb begin
      state_d     = state_q;
      walkIdx_d   = walkIdx_q;
      btbWe_d     = 1'b0;
      btbIndex_d  = '0;
      btbTag_d    = '0;
      btbTarget_d = '0;
      btbValid_d  = 1'b0;
      ctrWe       = 1'b0;
      ctrIdx      = headIdx;
      ctrVal      = WNT;
      fifoPop     = 1'b0;

      if (flush_req) begin
         state_d   = INIT;
         walkIdx_d = '0;
      end else begin
         case (state_q)
            INIT: begin
               btbWe_d    = 1'b1;
               btbIndex_d = walkIdx_q;
               ctrWe      = 1'b1;
               ctrIdx     = walkIdx_q;
               ctrVal     = WNT;
               walkIdx_d  = walkIdx_q + 1'b1;
               if (walkIdx_q == {INDEX_BITS{1'b1}}) state_d = RUN;
            end
            RUN: begin
               if (!fifoEmpty) begin
                  fifoPop = 1'b1;
                  ctrWe   = 1'b1;
                  ctrIdx  = headIdx;
                  if (headEntry.taken) begin
                     ctrVal      = satInc(ctr_q[headIdx]);
                     btbWe_d     = 1'b1;
                     btbIndex_d  = headIdx;
                     btbTag_d    = headEntry.pc_hi[29:INDEX_BITS];
                     btbTarget_d = headEntry.target;
                     btbValid_d  = 1'b1;
                  end else begin
                     ctrVal = satDec(ctr_q[headIdx]);
                     // Only a strongly-not-taken entry is worth evicting from the BTB.
                     if (ctrVal == SNT) begin
                        btbWe_d    = 1'b1;
                        btbIndex_d = headIdx;
                     end
                  end
               end
            end
            default: state_d = INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= INIT;
         walkIdx_q   <= '0;
         btbWe_q     <= 1'b0;
         btbIndex_q  <= '0;
         btbTag_q    <= '0;
         btbTarget_q <= '0;
         btbValid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         walkIdx_q   <= walkIdx_d;
         btbWe_q     <= btbWe_d;
         btbIndex_q  <= btbIndex_d;
         btbTag_q    <= btbTag_d;
         btbTarget_q <= btbTarget_d;
         btbValid_q  <= btbValid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) ctr_q[i] <= WNT;
      end else if (ctrWe) begin
         ctr_q[ctrIdx] <= ctrVal;
      end
   end

   assign btb_we        = btbWe_q;
   assign btb_index     = btbIndex_q;
   assign btb_tag       = btbTag_q;
   assign btb_target_wr = btbTarget_q;
   assign btb_valid_wr  = btbValid_q;

   // Lookup sees the counter before any same-cycle update; no bypass by design.
   assign pred_taken  = btb_tag_match && ctr_q[current_pc[INDEX_BITS+1:2]][1] && !busy;
   assign pred_target = pred_taken ? btb_target : 32'h0;

endmodule
